life_sequencer: RTL

Generation scheduler for the 8x8 Game-of-Life datapath. It holds the current 64-bit grid register and drives it into the combinational evolve datapath. It commits the datapath result either free-running at a programmable rate or one generation per step request. It counts generations and auto-halts a free run when the pattern becomes stable or extinct. It sits between the seed source (switch FSM / LFSR path) and the display, replacing direct mux selection with a sequenced update.

---
 rtl/life_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/life_sequencer.sv
// Generation scheduler for the 8x8 Life grid: holds the grid register, commits dp_evolve
// free-running every TICK_DIV cycles or once per step, counts generations, halts on still/extinct.
module life_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int GEN_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       seed,
    input  logic              load,
    input  logic              run,
    input  logic              step,
    input  logic [63:0]       dp_evolve,
    output logic [63:0]       grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic              busy,
    output logic              halted,
    output logic              stable,
    output logic              extinct,
    output logic              gen_tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic [63:0]        grid_q, grid_d;
    logic [GEN_W-1:0]   gen_q, gen_d;
    logic               stable_q, stable_d;
    logic               gen_tick_q;
    logic               busy_q;
    logic               halted_q;
    logic               commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            grid_q     <= '0;
            gen_q      <= '0;
            stable_q   <= 1'b0;
            gen_tick_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            grid_q     <= grid_d;
            gen_q      <= gen_d;
            stable_q   <= stable_d;
            gen_tick_q <= commit;
            busy_q     <= (state_d == S_RUN);
            halted_q   <= (state_d == S_HALT);
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        grid_d   = grid_q;
        gen_d    = gen_q;
        stable_d = stable_q;
        commit   = 1'b0;

        // load overrides every state and suppresses any commit this cycle
        if (load) begin
            state_d  = S_IDLE;
            tick_d   = '0;
            grid_d   = seed;
            gen_d    = '0;
            stable_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_d = S_RUN;
                        tick_d  = '0;
                    end else if (step) begin
                        state_d = S_STEP;
                    end
                end
                S_STEP: begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
                S_RUN: begin
                    if (!run) begin
                        state_d = S_IDLE;
                        tick_d  = '0;
                    end else if (tick_q == TICK_LAST) begin
                        commit = 1'b1;
                        tick_d = '0;
                        if ((dp_evolve == grid_q) || (dp_evolve == 64'd0)) begin
                            state_d = S_HALT;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_HALT: begin
                    if (!run) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (commit) begin
            grid_d   = dp_evolve;
            gen_d    = (gen_q == {GEN_W{1'b1}}) ? gen_q : gen_q + 1'b1;
            stable_d = (dp_evolve == grid_q);
        end
    end

    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign stable    = stable_q;
    assign extinct   = (grid_q == 64'd0);
    assign gen_tick  = gen_tick_q;

endmodule
